pulse_meas: RTL and testbench

PULSE_MEAS -- requirements
Module: pulse_meas

---
 rtl/pulse_meas.sv | 141 ++++++++++++++
 tb/tb_pulse_meas.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas.sv
// Pulse width / period meter fed by pin_capt edge strobes. Measures each high pulse
// and the preceding rise-to-rise interval in 1/8-cycle units and queues the results.
module pulse_meas #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_WIDTH  = 2,
  parameter int CNT_W      = 13
) (
  input  logic        clk300,
  input  logic        rst,
  input  logic        str,
  input  logic        pin_out,
  input  logic [2:0]  ptime,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_width,
  output logic [15:0] out_period,
  output logic        ovf,
  output logic [7:0]  drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int AW    = (CNT_W + 5 > 17) ? CNT_W + 5 : 17;

  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]        CNT_NEAR = CNT_MAX - CNT_W'(1);
  localparam logic signed [AW-1:0]    W_MAX    = AW'(65535);
  localparam logic [15:0]             MIN_W16  = 16'(MIN_WIDTH);
  localparam logic [PTR_W:0]          DEPTH_C  = FIFO_DEPTH[PTR_W:0];

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] period;
  } rec_t;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Counters hold (cycles elapsed - 1), so the elapsed count at an edge is cnt+1.
  // That makes the counter saturated when it reaches CNT_NEAR.
  function automatic logic [15:0] meas(input logic [CNT_W-1:0] cnt,
                                       input logic [2:0] t_end,
                                       input logic [2:0] t_start);
    logic [AW-1:0]        el;
    logic signed [AW-1:0] raw;
    el  = AW'(cnt) + AW'(1);
    raw = $signed((el << 3) + AW'(t_end) - AW'(t_start));
    if (cnt >= CNT_NEAR || raw > W_MAX) meas = 16'hFFFF;
    else                                meas = raw[15:0];
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt, per_cnt;
  logic [2:0]       t_rise;
  logic             first;
  logic [15:0]      per_lat;
  logic             rise_idle, rise_low, fall_high, dup;
  logic [15:0]      width_c, period_c;
  logic             runt;
  logic             rec_vld;
  rec_t             rec_q;

  rec_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, push, pop;

  always_comb begin
    state_d   = state_q;
    rise_idle = 1'b0;
    rise_low  = 1'b0;
    fall_high = 1'b0;
    dup       = 1'b0;
    if (str) begin
      case (state_q)
        IDLE: if (pin_out)  begin state_d = HIGH; rise_idle = 1'b1; end else dup = 1'b1;
        HIGH: if (!pin_out) begin state_d = LOW;  fall_high = 1'b1; end else dup = 1'b1;
        LOW:  if (pin_out)  begin state_d = HIGH; rise_low  = 1'b1; end else dup = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  assign width_c  = meas(hi_cnt, ptime, t_rise);
  assign period_c = meas(per_cnt, ptime, t_rise);
  assign runt     = fall_high && (width_c < MIN_W16);

  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = rec_vld && (!full || pop);

  always_ff @(posedge clk300) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_cnt   <= '0;
      per_cnt  <= '0;
      t_rise   <= '0;
      first    <= 1'b0;
      per_lat  <= '0;
      rec_vld  <= 1'b0;
      rec_q    <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state_q <= state_d;
      if (rise_idle || rise_low) begin
        t_rise  <= ptime;
        hi_cnt  <= '0;
        per_cnt <= '0;
        first   <= rise_idle;
        per_lat <= rise_idle ? 16'd0 : period_c;
      end else begin
        if (state_q == HIGH && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + CNT_W'(1);
        if (state_q != IDLE && per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
      end

      rec_vld      <= fall_high && !runt;
      rec_q.width  <= width_c;
      rec_q.period <= first ? 16'd0 : per_lat;

      if ((dup || runt) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      // A full FIFO only loses the record when nothing leaves in the same cycle.
      if (rec_vld && full && !pop) ovf <= 1'b1;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push && pop) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk300) begin
    if (push) mem[wr_ptr] <= rec_q;
  end

  assign out_width  = out_valid ? mem[rd_ptr].width  : 16'd0;
  assign out_period = out_valid ? mem[rd_ptr].period : 16'd0;

endmodule

// File: tb/tb_pulse_meas.sv
// Bench for pulse_meas: directed vector table, hand corner sequences and random
// edges, all checked against an edge-time/queue reference model.
module tb_pulse_meas;
  localparam int DEPTH = 4;
  localparam int MINW  = 2;
  localparam int CW    = 13;

  logic        clk300 = 1'b0;
  logic        rst = 1'b1, str = 1'b0, pin_out = 1'b0, out_ready = 1'b0;
  logic [2:0]  ptime = 3'd0;
  logic        out_valid, ovf;
  logic [15:0] out_width, out_period;
  logic [7:0]  drop_cnt;

  always #5 clk300 = ~clk300;

  pulse_meas #(.FIFO_DEPTH(DEPTH), .MIN_WIDTH(MINW), .CNT_W(CW)) dut (
    .clk300(clk300), .rst(rst), .str(str), .pin_out(pin_out), .ptime(ptime),
    .out_valid(out_valid), .out_ready(out_ready), .out_width(out_width),
    .out_period(out_period), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0, n_err = 0, cyc = 0, n_pop = 0;

  // Reference model: absolute edge times in 1/8 units, records in a bounded queue.
  typedef struct { int w; int p; } mrec_t;
  mrec_t mq[$];
  mrec_t pend;
  bit    pend_v = 0;
  int    m_ovf = 0, m_drop = 0;
  int    line = 0;  // 0 idle, 1 high, 2 low
  int    rise_cyc = 0, rise_abs = 0, cur_per = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int msat(input int dc, input int d);
    if (dc >= (1 << CW) - 1 || d > 65535) return 65535;
    return d;
  endfunction

  task automatic model_check();
    chk("out_valid", int'(out_valid), int'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_width", int'(out_width), mq[0].w);
      chk("out_period", int'(out_period), mq[0].p);
    end
    chk("ovf", int'(ovf), m_ovf);
    chk("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_edge(input bit s, input bit p, input int pt, input bit r, input bit rs);
    int ab, w;
    if (rs) begin
      mq.delete(); pend_v = 0; m_ovf = 0; m_drop = 0; line = 0;
      return;
    end
    if (mq.size() > 0 && r) void'(mq.pop_front());
    if (pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(pend);
      else m_ovf = 1;
      pend_v = 0;
    end
    if (s) begin
      ab = cyc * 8 + pt;
      if (p && line != 1) begin
        cur_per  = (line == 2) ? msat(cyc - rise_cyc, ab - rise_abs) : 0;
        rise_cyc = cyc; rise_abs = ab; line = 1;
      end else if (!p && line == 1) begin
        w = msat(cyc - rise_cyc, ab - rise_abs);
        line = 2;
        if (w < MINW) model_drop();
        else begin pend = '{w, cur_per}; pend_v = 1; end
      end else model_drop();
    end
  endtask

  task automatic tick();
    @(negedge clk300);
    model_check();
  endtask

  task automatic drive(input bit s, input bit p, input int pt, input bit r, input bit rs);
    if (out_valid && r && !rs) n_pop++;
    str = s; pin_out = p; ptime = 3'(pt); out_ready = r; rst = rs;
    model_edge(s, p, pt, r, rs);
    cyc++;
  endtask

  task automatic step(input bit s, input bit p, input int pt, input bit r, input bit rs);
    tick();
    drive(s, p, pt, r, rs);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(0, 0, 0, r, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    cyc = 0;
  endtask

  typedef struct { int cyc; bit s; bit p; int pt; bit ev; int ew; int ep; } vec_t;
  vec_t tbl[9];
  int   p0;

  initial begin
    tbl[0] = '{10, 1, 1, 2, 0, 0, 0};
    tbl[1] = '{13, 1, 0, 6, 0, 0, 0};
    tbl[2] = '{14, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{15, 0, 0, 0, 1, 28, 0};
    tbl[4] = '{16, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{20, 1, 1, 2, 0, 0, 0};
    tbl[6] = '{21, 1, 0, 1, 0, 0, 0};
    tbl[7] = '{23, 0, 0, 0, 1, 7, 80};
    tbl[8] = '{24, 0, 0, 0, 0, 0, 0};

    // Reset state.
    do_reset();
    tick();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_width", int'(out_width), 0);
    chk("reset out_period", int'(out_period), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset drop_cnt", int'(drop_cnt), 0);
    drive(0, 0, 0, 1, 0);

    // Directed vectors: first pulse and a following one.
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) step(0, 0, 0, 1, 0);
      tick();
      chk("tbl out_valid", int'(out_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl out_width", int'(out_width), tbl[i].ew);
        chk("tbl out_period", int'(out_period), tbl[i].ep);
      end
      drive(tbl[i].s, tbl[i].p, tbl[i].pt, 1, 0);
    end
    idle(4, 1);

    // Thirty pulses, 10 cycles apart, consumer always ready.
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 30; i++) begin
      step(1, 1, 3, 1, 0); idle(2, 1); step(1, 0, 5, 1, 0); idle(6, 1);
    end
    idle(4, 1);
    chk("train pops", n_pop - p0, 30);
    chk("train ovf", int'(ovf), 0);

    // Five pulses with no consumer: four kept, overflow flagged, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 0); idle(2, 0); step(1, 0, 4, 0, 0); idle(6, 0);
    end
    idle(3, 0);
    chk("full ovf", int'(ovf), 1);
    chk("full valid", int'(out_valid), 1);
    chk("full head width", int'(out_width), 28);
    p0 = n_pop;
    idle(10, 1);
    chk("drain pops", n_pop - p0, 4);
    chk("drain ovf sticky", int'(ovf), 1);

    // Duplicate rise then runt pulse.
    do_reset();
    step(1, 1, 0, 0, 0); idle(1, 0); step(1, 1, 0, 0, 0); idle(1, 0); step(1, 0, 4, 0, 0);
    idle(3, 0);
    chk("dup drop_cnt", int'(drop_cnt), 1);
    chk("dup valid", int'(out_valid), 1);
    chk("dup width", int'(out_width), 36);
    idle(2, 1);
    step(1, 1, 7, 1, 0); step(1, 0, 0, 1, 0);
    idle(3, 1);
    chk("runt drop_cnt", int'(drop_cnt), 2);
    chk("runt no record", int'(out_valid), 0);

    // Long high time saturates, then reset mid-pulse.
    do_reset();
    step(1, 1, 1, 1, 0);
    idle(8999, 1);
    step(1, 0, 1, 0, 0);
    idle(2, 0);
    chk("sat valid", int'(out_valid), 1);
    chk("sat width", int'(out_width), 65535);
    step(1, 1, 3, 0, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 1);
    tick();
    chk("mid rst valid", int'(out_valid), 0);
    chk("mid rst width", int'(out_width), 0);
    chk("mid rst period", int'(out_period), 0);
    chk("mid rst ovf", int'(ovf), 0);
    chk("mid rst drop", int'(drop_cnt), 0);
    drive(0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0); idle(2, 0); step(1, 0, 2, 0, 0); idle(2, 0);
    chk("post rst valid", int'(out_valid), 1);
    chk("post rst period", int'(out_period), 0);
    chk("post rst width", int'(out_width), 24);
    idle(2, 1);

    // Random edges, random consumer, rare resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit rs;
      rs = ($urandom_range(0, 999) == 0);
      step(!rs && $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, rs);
    end
    idle(8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
